// File: rtl/mr_wb_arb.sv
// N-master to 1-slave pipelined Wishbone arbiter.
// One master owns the slave port for a whole CYC envelope; responses go back to
// that master only, and accepted-but-unanswered strobes are capped at MAX_OUTST.
module mr_wb_arb #(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [NUM_M-1:0]        m_stall_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_stall_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [GW-1:0]   win_c;
    logic            cap_full_c;
    logic            stb_acc_c;
    logic            rsp_c;
    logic            busy_c;

    // Read data is simply broadcast; only the ACK/ERR strobes are steered.
    assign m_dat_o = s_dat_i;

    // Winner search: from rr_ptr upward with wrap (round-robin) or lowest index (fixed).
    always_comb begin
        logic found;
        found = 1'b0;
        win_c = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!found && m_cyc_i[i] && ((PRIO_MODE != 0) || (i >= 32'(rr_ptr_q)))) begin
                found = 1'b1;
                win_c = GW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!found && m_cyc_i[i]) begin
                found = 1'b1;
                win_c = GW'(i);
            end
        end
    end

    // Next-state logic and combinational routing of the granted master.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        m_ack_o    = '0;
        m_err_o    = '0;
        m_stall_o  = '1;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = m_we_i[gnt_q];
        s_adr_o    = m_adr_i[32'(gnt_q) * AW +: AW];
        s_dat_o    = m_dat_i[32'(gnt_q) * DW +: DW];
        s_sel_o    = m_sel_i[32'(gnt_q) * SW +: SW];
        cap_full_c = (cnt_q == CW'(MAX_OUTST));
        busy_c     = (state_q == ST_BUSY) && m_cyc_i[gnt_q];
        stb_acc_c  = 1'b0;
        rsp_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    gnt_d   = win_c;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (busy_c) begin
                    s_cyc_o            = 1'b1;
                    s_stb_o            = m_stb_i[gnt_q] && !cap_full_c;
                    m_stall_o[gnt_q]   = s_stall_i || cap_full_c;
                    // Responses with nothing outstanding are spurious and swallowed.
                    rsp_c              = (s_ack_i || s_err_i) && (cnt_q != '0);
                    m_ack_o[gnt_q]     = s_ack_i && (cnt_q != '0);
                    m_err_o[gnt_q]     = s_err_i && (cnt_q != '0);
                    stb_acc_c          = s_stb_o && !s_stall_i;
                    if (stb_acc_c && !rsp_c) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (!stb_acc_c && rsp_c) begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    // Master dropped CYC: release (an abort if strobes are still open).
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = (32'(gnt_q) == NUM_M - 1) ? '0 : gnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Bench for mr_wb_arb: directed scenarios on a 3-master round-robin instance and a
// 2-master fixed-priority instance, then a randomized run against a counting model.
module tb_mr_wb_arb;

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack, m_err, m_stall;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [DW/8-1:0]   s_sel;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err, s_stall;

    logic [1:0]        p_cyc;
    logic [DW-1:0]     p_dat_o;
    logic [1:0]        p_ack, p_err, p_stall;
    logic              p_scyc, p_sstb, p_swe;
    logic [AW-1:0]     p_sadr;
    logic [DW-1:0]     p_sdat;
    logic [DW/8-1:0]   p_ssel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mr_wb_arb #(.NUM_M(NM), .AW(AW), .DW(DW), .MAX_OUTST(MO), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err), .m_stall_o(m_stall),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall)
    );

    mr_wb_arb #(.NUM_M(2), .AW(AW), .DW(DW), .MAX_OUTST(MO), .PRIO_MODE(1)) u_pr (
        .clk(clk), .rst(rst),
        .m_cyc_i(p_cyc), .m_stb_i(m_stb[1:0]), .m_we_i(m_we[1:0]),
        .m_adr_i(m_adr[2*AW-1:0]), .m_dat_i(m_dat[2*DW-1:0]), .m_sel_i(m_sel[2*DW/8-1:0]),
        .m_dat_o(p_dat_o), .m_ack_o(p_ack), .m_err_o(p_err), .m_stall_o(p_stall),
        .s_cyc_o(p_scyc), .s_stb_o(p_sstb), .s_we_o(p_swe), .s_adr_o(p_sadr),
        .s_dat_o(p_sdat), .s_sel_o(p_ssel),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse reset for one edge with all inputs idle; returns at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        p_cyc = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Count strobes the slave accepts over n cycles; starts and ends at a falling edge.
    task automatic count_acc(input int n, output int acc);
        acc = 0;
        repeat (n) begin
            #1;
            if (s_stb && !s_stall) acc++;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) until one master of the chosen instance is unstalled; -1 on timeout.
    task automatic wait_grant(input bit prio, output int g);
        g = -1;
        for (int t = 0; t < 8 && g < 0; t++) begin
            @(negedge clk);
            #1;
            if (prio) begin
                for (int i = 0; i < 2; i++) if (!p_stall[i]) g = i;
            end else begin
                for (int i = 0; i < int'(NM); i++) if (!m_stall[i]) g = i;
            end
        end
    endtask

    initial begin
        int a;
        int g;
        int exp_rr [4] = '{0, 1, 0, 1};
        int iss [NM];
        int outst [NM];
        int acc_tot [NM];
        int ack_tot [NM];
        bit acc_p [NM];
        bit ack_p [NM];
        bit sacc_p, sack_p;
        int pend;
        bit draining;

        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        p_cyc = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_sstb", 64'(s_stb), 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_stall", 64'(m_stall), 64'h7);
        chk("rst_pstall", 64'(p_stall), 64'h3);

        // Single read from master 0.
        @(negedge clk);
        rst = 1'b0; m_cyc = 3'b001; m_stb = 3'b001; m_adr[31:0] = 32'h100; m_sel[3:0] = 4'hF;
        #1;
        chk("t1_idle_scyc", 64'(s_cyc), 64'd0);
        chk("t1_idle_stall", 64'(m_stall), 64'h7);
        @(negedge clk);
        #1;
        chk("t1_scyc", 64'(s_cyc), 64'd1);
        chk("t1_sstb", 64'(s_stb), 64'd1);
        chk("t1_sadr", 64'(s_adr), 64'h100);
        chk("t1_stall", 64'(m_stall), 64'h6);
        @(negedge clk);
        m_stb = '0; s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        #1;
        chk("t1_ack", 64'(m_ack), 64'h1);
        chk("t1_dat", 64'(m_dat_o), 64'hDEADBEEF);
        chk("t1_err", 64'(m_err), 64'd0);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = '0;
        #1;
        chk("t1_release", 64'(s_cyc), 64'd0);

        // Round-robin grant sequence with two persistent requesters.
        do_reset();
        m_cyc = 3'b011;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1'b0, g);
            chk("t2_rr_gnt", 64'(g), 64'(exp_rr[k]));
            if (g >= 0) begin
                @(negedge clk); m_cyc[g] = 1'b0;
                @(negedge clk); m_cyc[g] = 1'b1;
            end
        end
        m_cyc = '0;

        // Fixed priority: master 0 always wins while it keeps requesting.
        do_reset();
        p_cyc = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(1'b1, g);
            chk("t2_prio_gnt", 64'(g), 64'd0);
            if (g >= 0) begin
                @(negedge clk); p_cyc[g] = 1'b0;
                @(negedge clk); p_cyc[g] = 1'b1;
            end
        end
        p_cyc = '0;

        // Outstanding cap with a silent slave.
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        count_acc(10, a);
        chk("t3_cap_accepts", 64'(a), 64'd4);
        #1;
        chk("t3_cap_stall", 64'(m_stall[0]), 64'd1);
        chk("t3_cap_sstb", 64'(s_stb), 64'd0);
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("t3_cap_ack", 64'(m_ack), 64'h1);
        @(negedge clk);
        s_ack = 1'b0;
        count_acc(5, a);
        chk("t3_one_more", 64'(a), 64'd1);

        // Simultaneous accept and ack at cnt=2, then ERR at cnt=1.
        m_stb = '0; s_ack = 1'b1;
        repeat (2) begin #1; @(negedge clk); end
        m_stb = 3'b001; s_ack = 1'b1;
        #1;
        chk("t4_sim_sstb", 64'(s_stb), 64'd1);
        @(negedge clk);
        s_ack = 1'b0;
        count_acc(6, a);
        chk("t4_cnt_held", 64'(a), 64'd2);
        m_stb = '0; s_ack = 1'b1;
        repeat (3) begin #1; @(negedge clk); end
        s_ack = 1'b0; s_err = 1'b1;
        #1;
        chk("t4_err", 64'(m_err), 64'h1);
        chk("t4_err_noack", 64'(m_ack), 64'd0);
        @(negedge clk);
        s_err = 1'b0; m_stb = 3'b001;
        count_acc(8, a);
        chk("t4_cnt_zero", 64'(a), 64'd4);

        // Abort by master 1 with three strobes open.
        do_reset();
        m_cyc = 3'b010; m_stb = 3'b010; m_adr[63:32] = 32'h200;
        count_acc(4, a);
        chk("t5_accepts", 64'(a), 64'd3);
        m_stb = '0; m_cyc = '0;
        #1;
        chk("t5_scyc_drop", 64'(s_cyc), 64'd0);
        chk("t5_sstb_drop", 64'(s_stb), 64'd0);
        @(negedge clk);
        m_cyc = 3'b001; s_ack = 1'b1;
        #1;
        chk("t5_idle_stall", 64'(m_stall), 64'h7);
        chk("t5_idle_scyc", 64'(s_cyc), 64'd0);
        chk("t5_idle_ack", 64'(m_ack), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_m0_scyc", 64'(s_cyc), 64'd1);
        chk("t5_m0_stall", 64'(m_stall), 64'h6);
        chk("t5_m0_noack", 64'(m_ack), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_m0_noack2", 64'(m_ack), 64'd0);
        @(negedge clk);
        s_ack = 1'b0; m_cyc = '0;

        // Reset in the middle of a burst with two strobes open.
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        count_acc(3, a);
        chk("t6_accepts", 64'(a), 64'd2);
        rst = 1'b1; s_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_scyc", 64'(s_cyc), 64'd0);
        chk("t6_sstb", 64'(s_stb), 64'd0);
        chk("t6_stall", 64'(m_stall), 64'h7);
        chk("t6_ack", 64'(m_ack), 64'd0);
        chk("t6_err", 64'(m_err), 64'd0);
        @(negedge clk);
        rst = 1'b0; s_ack = 1'b0;
        count_acc(8, a);
        chk("t6_cnt_zero", 64'(a), 64'd4);

        // Randomized three-master traffic against a per-master completion count.
        do_reset();
        pend = 0; sacc_p = 1'b0; sack_p = 1'b0; draining = 1'b0;
        for (int i = 0; i < int'(NM); i++) begin
            iss[i] = 0; outst[i] = 0; acc_tot[i] = 0; ack_tot[i] = 0;
            acc_p[i] = 1'b0; ack_p[i] = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            draining = (c >= 9700);
            for (int i = 0; i < int'(NM); i++) begin
                if (acc_p[i]) begin iss[i]--; outst[i]++; acc_tot[i]++; end
                if (ack_p[i]) begin outst[i]--; ack_tot[i]++; end
            end
            if (sacc_p) pend++;
            if (sack_p) pend--;
            for (int i = 0; i < int'(NM); i++) begin
                if (!m_cyc[i]) begin
                    if (!draining && $urandom_range(3) == 0) begin
                        m_cyc[i] = 1'b1;
                        iss[i] = int'($urandom_range(6, 1));
                    end
                end else if (iss[i] == 0 && outst[i] == 0) begin
                    m_cyc[i] = 1'b0;
                end
                m_stb[i] = m_cyc[i] && (iss[i] > 0) && ($urandom_range(3) != 0);
                m_we[i] = 1'($urandom);
                m_adr[i*AW +: AW] = $urandom;
                m_dat[i*DW +: DW] = $urandom;
                m_sel[i*DW/8 +: DW/8] = 4'($urandom);
            end
            s_stall = ($urandom_range(3) == 0);
            s_ack = 1'b0; s_err = 1'b0;
            if (pend > 0 && $urandom_range(1) == 1) begin
                if ($urandom_range(9) == 0) s_err = 1'b1;
                else s_ack = 1'b1;
            end
            s_dat = $urandom;
            #1;
            for (int i = 0; i < int'(NM); i++) begin
                acc_p[i] = m_stb[i] && !m_stall[i];
                ack_p[i] = m_ack[i] || m_err[i];
                chk("rnd_stray_rsp", 64'(ack_p[i] && outst[i] == 0), 64'd0);
                chk("rnd_cap", 64'(outst[i] + int'(acc_p[i]) > int'(MO)), 64'd0);
            end
            sacc_p = s_stb && !s_stall;
            sack_p = s_ack || s_err;
            chk("rnd_slave_accept", 64'(sacc_p), 64'(acc_p[0] || acc_p[1] || acc_p[2]));
            chk("rnd_rsp_route", 64'($countones(m_ack | m_err)), 64'(sack_p));
            @(negedge clk);
        end
        for (int i = 0; i < int'(NM); i++) begin
            if (acc_p[i]) acc_tot[i]++;
            if (ack_p[i]) ack_tot[i]++;
        end
        chk("rnd_drained", 64'(m_cyc), 64'd0);
        for (int i = 0; i < int'(NM); i++) begin
            chk("rnd_ack_vs_stb", 64'(ack_tot[i]), 64'(acc_tot[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
